// File: rtl/counter_pkg.sv
// Shared types and default widths for the counter arbiter.
// State encoding is fixed so waveforms read the same across builds.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int CNT_W_DEF   = 5;
  localparam int PRESC_W_DEF = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last grant.
// Returns a one-hot grant, its index, and whether anything was picked.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid                = 1'b1;
        gnt[IDX_W'(cand)]    = 1'b1;
        idx                  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Time-shares one prescaled counter among several requesters.
// Grants round-robin, clears and runs the counter, pulses done on match.
import counter_pkg::*;

module counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*PRESC_W-1:0] req_prescaler,
  input  logic [NUM_REQ*CNT_W-1:0]   req_target,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic                       cnt_reset,
  output logic [PRESC_W-1:0]         cnt_prescaler,
  input  logic [CNT_W-1:0]           cnt_value
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 cnt_reset_q, cnt_reset_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    target_d    = target_q;
    presc_d     = presc_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    busy_d      = busy_q;
    cnt_reset_d = cnt_reset_q;
    unique case (state_q)
      IDLE: begin
        gnt_d       = '0;
        busy_d      = 1'b0;
        cnt_reset_d = 1'b1;
        if (pick_valid) begin
          state_d  = CLEAR;
          idx_d    = pick_idx;
          gnt_d    = pick_gnt;
          busy_d   = 1'b1;
          presc_d  = req_prescaler[int'(pick_idx)*PRESC_W +: PRESC_W];
          target_d = req_target[int'(pick_idx)*CNT_W +: CNT_W];
        end
      end
      CLEAR: begin
        state_d     = RUN;
        cnt_reset_d = 1'b0;
      end
      RUN: begin
        // A match in the same cycle as a withdraw still completes.
        if (cnt_value == target_q) begin
          state_d       = DONE;
          done_d[idx_q] = 1'b1;
          cnt_reset_d   = 1'b1;
        end else if (!req[idx_q]) begin
          state_d     = IDLE;
          gnt_d       = '0;
          busy_d      = 1'b0;
          cnt_reset_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      target_q    <= '0;
      presc_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      cnt_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      target_q    <= target_d;
      presc_q     <= presc_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cnt_reset_q <= cnt_reset_d;
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign cnt_reset     = cnt_reset_q;
  assign cnt_prescaler = presc_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural prescaled counter.
// Expected values are hand-derived cycle counts and grant orders.
module tb_counter_arbiter;

  localparam int N  = 4;
  localparam int CW = 5;
  localparam int PW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*PW-1:0] req_prescaler = '0;
  logic [N*CW-1:0] req_target = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            busy;
  logic            cnt_reset;
  logic [PW-1:0]   cnt_prescaler;
  logic [CW-1:0]   cnt_value = '0;
  logic [PW-1:0]   div_q = '0;

  int checks   = 0;
  int failures = 0;
  int multi    = 0;
  int n        = 0;

  counter_arbiter #(
    .NUM_REQ (N),
    .CNT_W   (CW),
    .PRESC_W (PW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_prescaler (req_prescaler),
    .req_target    (req_target),
    .gnt           (gnt),
    .done          (done),
    .busy          (busy),
    .cnt_reset     (cnt_reset),
    .cnt_prescaler (cnt_prescaler),
    .cnt_value     (cnt_value)
  );

  always #5 clock = ~clock;

  // Counter datapath: held at 0 in reset, steps every prescaler+1 clocks.
  always @(posedge clock) begin
    if (cnt_reset) begin
      cnt_value <= '0;
      div_q     <= '0;
    end else if (div_q == cnt_prescaler) begin
      div_q     <= '0;
      cnt_value <= cnt_value + 1'b1;
    end else begin
      div_q <= div_q + 1;
    end
  end

  always @(negedge clock) begin
    if (reset && ($countones(gnt) > 1 || $countones(done) > 1 ||
                  (done & ~gnt) != '0))
      multi++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [PW-1:0] p,
                         input logic [CW-1:0] t);
    req_prescaler[i*PW +: PW] = p;
    req_target[i*CW +: CW]    = t;
  endtask

  task automatic wait_gnt(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (gnt == '0 && k < 64);
    check({tag, "_gnt_seen"}, 32'(gnt != '0), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int cyc);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (done == '0 && k < 64);
    cyc = k;
    check({tag, "_done_seen"}, 32'(done != '0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt_reset", 32'(cnt_reset), 32'h1);
    check("rst_presc", cnt_prescaler, 32'h0);

    // Single request, prescaler 0, target 5
    @(negedge clock);
    reset = 1'b1;
    set_req(0, 0, 5);
    req = 4'b0001;
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_clear", 32'(cnt_reset), 32'h1);
    tick();
    check("t1_run_rst", 32'(cnt_reset), 32'h0);
    check("t1_cnt0", 32'(cnt_value), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1_cnt", 32'(cnt_value), 32'(k));
      check("t1_nodone", 32'(done), 32'h0);
    end
    tick();
    check("t1_done", 32'(done), 32'h1);
    check("t1_done_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    check("t1_done_off", 32'(done), 32'h0);
    check("t1_gnt_off", 32'(gnt), 32'h0);
    check("t1_busy_off", 32'(busy), 32'h0);
    check("t1_park", 32'(cnt_reset), 32'h1);

    // Prescaler 3, target 2; inputs change after grant
    set_req(2, 3, 2);
    req = 4'b0100;
    tick();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_presc", cnt_prescaler, 32'd3);
    set_req(2, 7, 9);
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t2_cnt", 32'(cnt_value), 32'(k / 4));
      check("t2_nodone", 32'(done), 32'h0);
      check("t2_presc_hold", cnt_prescaler, 32'd3);
    end
    tick();
    check("t2_done", 32'(done), 32'h4);
    req = '0;
    tick();
    check("t2_gnt_off", 32'(gnt), 32'h0);

    // Target 0 completes in the first RUN cycle
    set_req(1, 1, 0);
    req = 4'b0010;
    tick();
    check("t3_gnt", 32'(gnt), 32'h2);
    tick();
    check("t3_cnt_run", 32'(cnt_value), 32'h0);
    check("t3_nodone", 32'(done), 32'h0);
    tick();
    check("t3_done", 32'(done), 32'h2);
    check("t3_cnt_done", 32'(cnt_value), 32'h0);
    req = '0;
    tick();
    check("t3_gnt_off", 32'(gnt), 32'h0);
    check("t3_cnt_after", 32'(cnt_value), 32'h0);

    // Abort after 10 RUN cycles, then requester 3 runs normally
    set_req(0, 0, 31);
    req = 4'b0001;
    tick();
    check("t4_gnt", 32'(gnt), 32'h1);
    tick();
    for (int k = 1; k <= 10; k++) tick();
    check("t4_cnt10", 32'(cnt_value), 32'd10);
    set_req(3, 0, 2);
    req = 4'b1000;
    tick();
    check("t4_abort_gnt", 32'(gnt), 32'h0);
    check("t4_abort_done", 32'(done), 32'h0);
    check("t4_abort_busy", 32'(busy), 32'h0);
    check("t4_abort_park", 32'(cnt_reset), 32'h1);
    tick();
    check("t4_next_gnt", 32'(gnt), 32'h8);
    wait_done("t4", n);
    check("t4_next_done", 32'(done), 32'h8);
    check("t4_next_lat", 32'(n), 32'd4);
    req = '0;
    tick();
    check("t4_gnt_off", 32'(gnt), 32'h0);

    // Round robin with all requesters held
    for (int i = 0; i < N; i++) set_req(i, 0, 1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr");
      check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      wait_done("rr", n);
      check("rr_done", 32'(done), 32'(1 << (k % 4)));
      if (k == 4) req = '0;
    end
    tick();
    check("rr_gnt_off", 32'(gnt), 32'h0);
    check("rr_onehot", 32'(multi), 32'h0);

    // Async reset in the middle of RUN
    for (int i = 0; i < N; i++) set_req(i, 0, 31);
    req = 4'b1111;
    wait_gnt("ar");
    check("ar_gnt", 32'(gnt), 32'h2);
    tick();
    tick();
    tick();
    #1 reset = 1'b0;
    #1;
    check("ar_gnt_rst", 32'(gnt), 32'h0);
    check("ar_busy_rst", 32'(busy), 32'h0);
    check("ar_park_rst", 32'(cnt_reset), 32'h1);
    check("ar_done_rst", 32'(done), 32'h0);
    #4 reset = 1'b1;
    tick();
    check("ar_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();
    tick();
    check("ar_abort_gnt", 32'(gnt), 32'h0);
    check("ar_abort_busy", 32'(busy), 32'h0);
    check("final_onehot", 32'(multi), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one prescaled `counter` instance among NUM_REQ requesters.
- Each requester asks for a delay expressed as a prescaler value plus a target count.
- The block grants the counter round-robin, clears and programs it, watches `counter_out` for the target, then pulses a per-requester done.
- Sits between timing clients and the single counter datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 5, counter width; matches `counter_out`
- PRESC_W, 32, prescaler width; matches `counter.prescaler`

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request level; held until done or withdrawn
- req_prescaler  in  NUM_REQ*PRESC_W  packed prescaler per requester; slice i at [i*PRESC_W +: PRESC_W]
- req_target  in  NUM_REQ*CNT_W  packed target count per requester; slice i at [i*CNT_W +: CNT_W]
- gnt  out  NUM_REQ  one-hot grant; all-zero when idle
- done  out  NUM_REQ  one-cycle pulse on target match for the granted requester
- busy  out  1  high while any grant is held
- cnt_reset  out  1  drives `counter.reset`, active-high
- cnt_prescaler  out  PRESC_W  drives `counter.prescaler`
- cnt_value  in  CNT_W  from `counter.counter_out`

Behaviour:
- Counter contract:
  - While `cnt_reset`=1, the counter's `counter_out` is held at 0.
  - Once `cnt_reset`=0, it increments once every `cnt_prescaler`+1 clocks and wraps modulo 2^CNT_W.
- All outputs are registered. Reset values:
  - `gnt`=0, `done`=0, `busy`=0
  - `cnt_reset`=1, `cnt_prescaler`=0
  - state=IDLE; rr pointer gives requester 0 highest priority first.
- FSM states: IDLE, CLEAR, RUN, DONE.
  - IDLE: `cnt_reset`=1, `gnt`=0.
    - If any `req` bit is set, pick the first requester at or after pointer+1 (mod NUM_REQ).
    - Latch its index, prescaler and target; go to CLEAR.
  - CLEAR (1 cycle): `gnt`[idx]=1, `busy`=1, `cnt_reset`=1, `cnt_prescaler`=latched value. Go to RUN.
  - RUN: `cnt_reset`=0, `gnt` held.
    - If `cnt_value` == latched target, go to DONE.
    - Else if `req`[idx]=0 (withdrawn), go to IDLE with no done pulse (abort).
  - DONE (1 cycle): `done`[idx]=1, `gnt` held, `cnt_reset`=1. Pointer := idx. Go to IDLE.
- Latency:
  - `req` seen in IDLE at cycle t → `gnt` visible at t+1, RUN at t+2.
  - Match seen in RUN at cycle k → `done` at k+1, `gnt` low at k+2.
- Target 0: matches in the first RUN cycle, so `done` arrives at t+3.
- Latched prescaler/target are immune to input changes after grant; `cnt_prescaler` is stable for the whole grant.
- Simultaneous match and withdraw in the same RUN cycle: match wins, `done` pulses.
- A requester whose `req` is still high in IDLE after its DONE is re-eligible, but after all other requesters in rr order.
- Arithmetic: equality compare only; the target is always reachable because it is less than 2^CNT_W. No overflow handling is needed.
- Reset asserted mid-operation: immediate return to reset values. `cnt_reset`=1 parks the counter, and no done pulse is issued.
- `done` and `gnt` are never set for more than one requester at a time.

Decomposition:
- Shared package (counter_pkg): state encoding (IDLE=0, CLEAR=1, RUN=2, DONE=3) and default widths CNT_W=5, PRESC_W=32.
- Natural sub-module: `rr_arbiter`.
  - Combinational one-hot round-robin pick from the `req` vector and the last-grant pointer, parameterised by NUM_REQ.
  - The FSM, latches and pointer register stay in `counter_arbiter`.

Test Plan:
- Single request: `req`=0001, prescaler=0, target=5, counter attached → `gnt`=0001 at t+1; `cnt_value` 0..5 over RUN; `done`[0] pulses exactly once at 6 clocks after RUN entry; `gnt`=0 the next cycle.
- Prescaler: `req`[2], prescaler=3, target=2 → `cnt_value` steps every 4 clocks; `done`[2] arrives 8 clocks (+1 register) after RUN entry; `cnt_prescaler`=3 throughout the grant.
- Round-robin: `req`=1111 held, all target=1 → grant order 0,1,2,3,0; never two `gnt` bits set; each `done` precedes the next `gnt`.
- Target 0: `req`[1], target=0 → `done`[1] at t+3; counter never leaves 0.
- Abort: `req`[0], target=31, deassert `req`[0] at cycle 10 of RUN → no `done`; IDLE next; `cnt_reset`=1; next `req`[3] granted normally.
- Async reset mid-RUN (`reset`=0 for 5 ns between edges) → `gnt`=0, `busy`=0 and `cnt_reset`=1 immediately without a clock edge; after release, the first grant goes to requester 0 if `req`=1111.
